// File: rtl/pmp_pkg.sv
// Shared types and constants for the pmp_array pattern matcher.
package pmp_pkg;

  typedef enum logic [1:0] {
    OP_DATA   = 2'd0,
    OP_LOAD   = 2'd1,
    OP_SETLEN = 2'd2,
    OP_CLEAR  = 2'd3
  } opcode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  localparam int OP_LSB       = 0;
  localparam int IDX_LSB      = 4;
  localparam int LEN_LSB      = 8;
  localparam int MASK_SEL_BIT = 12;
  localparam int FIELD_W      = 4;
  localparam int CNT_W        = 8;

endpackage

// File: rtl/pmp_channel.sv
// One matcher channel: handshake FSM, pattern (and, with PMP_MASK_EN, mask)
// storage, match pointer and saturating match counter.
module pmp_channel
  import pmp_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int CTRL_W    = 16,
  parameter int PAT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [CTRL_W-1:0] control,
  input  logic              data_ready,
  output logic              data_accepted,
  output logic              pattern_accepted,
  output logic [CNT_W-1:0]  match_cnt
);

  // Handshake: 4-phase. data_ready rises with data/control stable; the command
  // executes on the IDLE->ACK edge and data_accepted rises the next cycle.
  // data_ready falls only after data_accepted is seen; data_accepted then falls.
  state_t state;

  logic [DATA_W-1:0] pattern [PAT_DEPTH];
`ifdef PMP_MASK_EN
  logic [DATA_W-1:0] mask [PAT_DEPTH];
  logic [DATA_W-1:0] msk_ptr;
`endif

  logic [FIELD_W-1:0] ptr;
  logic [FIELD_W:0]   len;

  opcode_t            op;
  logic [FIELD_W-1:0] idx;
  logic [FIELD_W-1:0] len_req;
  logic               idx_ok;
  logic               at_last;
  logic [DATA_W-1:0]  pat_ptr;
  logic               hit_ptr;
  logic               hit_zero;
  logic [CNT_W-1:0]   cnt_next;
  logic               unused_ctrl;

  assign op          = opcode_t'(control[OP_LSB +: 2]);
  assign idx         = control[IDX_LSB +: FIELD_W];
  assign len_req     = control[LEN_LSB +: FIELD_W];
  assign idx_ok      = {1'b0, idx} < (FIELD_W+1)'(PAT_DEPTH);
  assign at_last     = {1'b0, ptr} == len - (FIELD_W+1)'(1);
  assign cnt_next    = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
  assign unused_ctrl = ^control;

  always_comb begin
    pat_ptr = '0;
`ifdef PMP_MASK_EN
    msk_ptr = '1;
`endif
    for (int k = 0; k < PAT_DEPTH; k++) begin
      if (ptr == FIELD_W'(k)) begin
        pat_ptr = pattern[k];
`ifdef PMP_MASK_EN
        msk_ptr = mask[k];
`endif
      end
    end
`ifdef PMP_MASK_EN
    hit_ptr  = (data & msk_ptr) == (pat_ptr & msk_ptr);
    hit_zero = (data & mask[0]) == (pattern[0] & mask[0]);
`else
    hit_ptr  = data == pat_ptr;
    hit_zero = data == pattern[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      data_accepted    <= 1'b0;
      pattern_accepted <= 1'b0;
      match_cnt        <= '0;
      ptr              <= '0;
      len              <= '0;
      for (int k = 0; k < PAT_DEPTH; k++) begin
        pattern[k] <= '0;
`ifdef PMP_MASK_EN
        mask[k]    <= '1;
`endif
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_ready) begin
            state         <= ST_ACK;
            data_accepted <= 1'b1;
            case (op)
              OP_DATA: begin
                if (len == '0) begin
                  ptr <= '0;
                end else if (hit_ptr) begin
                  if (at_last) begin
                    pattern_accepted <= 1'b1;
                    match_cnt        <= cnt_next;
                    ptr              <= '0;
                  end else begin
                    ptr <= ptr + FIELD_W'(1);
                  end
                end else if (hit_zero) begin
                  // Restart only from pattern[0]; no deeper fallback.
                  if (len == (FIELD_W+1)'(1)) begin
                    pattern_accepted <= 1'b1;
                    match_cnt        <= cnt_next;
                    ptr              <= '0;
                  end else begin
                    ptr <= FIELD_W'(1);
                  end
                end else begin
                  ptr <= '0;
                end
              end
              OP_LOAD: begin
                if (idx_ok) begin
                  for (int k = 0; k < PAT_DEPTH; k++) begin
                    if (idx == FIELD_W'(k)) begin
`ifdef PMP_MASK_EN
                      if (control[MASK_SEL_BIT]) mask[k] <= data;
                      else                       pattern[k] <= data;
`else
                      pattern[k] <= data;
`endif
                    end
                  end
                  ptr              <= '0;
                  pattern_accepted <= 1'b0;
                end
              end
              OP_SETLEN: begin
                if ({1'b0, len_req} > (FIELD_W+1)'(PAT_DEPTH))
                  len <= (FIELD_W+1)'(PAT_DEPTH);
                else
                  len <= {1'b0, len_req};
                ptr <= '0;
              end
              OP_CLEAR: begin
                pattern_accepted <= 1'b0;
                match_cnt        <= '0;
                ptr              <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_ACK: begin
          if (!data_ready) begin
            state         <= ST_IDLE;
            data_accepted <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          data_accepted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pmp_array.sv
// Array of NUM_CH independent pattern-matcher channels; only slices the buses.
// Optional masked compare is enabled by defining PMP_MASK_EN.
module pmp_array
  import pmp_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 64,
  parameter int CTRL_W    = 16,
  parameter int PAT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic [NUM_CH*CTRL_W-1:0] control,
  input  logic [NUM_CH-1:0]        data_ready,
  output logic [NUM_CH-1:0]        data_accepted,
  output logic [NUM_CH-1:0]        pattern_accepted,
  output logic [NUM_CH*CNT_W-1:0]  match_cnt
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pmp_channel #(
      .DATA_W    (DATA_W),
      .CTRL_W    (CTRL_W),
      .PAT_DEPTH (PAT_DEPTH)
    ) u_ch (
      .clk              (clk),
      .reset            (reset),
      .data             (data[i*DATA_W +: DATA_W]),
      .control          (control[i*CTRL_W +: CTRL_W]),
      .data_ready       (data_ready[i]),
      .data_accepted    (data_accepted[i]),
      .pattern_accepted (pattern_accepted[i]),
      .match_cnt        (match_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_pmp_array.sv
// Directed bench for pmp_array: vector table on channel 0 plus hand-written
// handshake, saturation, clamp, mask and mid-transaction reset sequences.
module tb_pmp_array;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;
  localparam int PAT_DEPTH = 4;

  localparam logic [1:0] C_DATA = 2'd0;
  localparam logic [1:0] C_LOAD = 2'd1;
  localparam logic [1:0] C_SETLEN = 2'd2;
  localparam logic [1:0] C_CLEAR = 2'd3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH*CTRL_W-1:0] control;
  logic [NUM_CH-1:0]        data_ready;
  logic [NUM_CH-1:0]        data_accepted;
  logic [NUM_CH-1:0]        pattern_accepted;
  logic [NUM_CH*8-1:0]      match_cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  idx;
    logic [3:0]  ln;
    logic        msel;
    logic [63:0] wd;
    logic        exp_acc;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];
  logic [8:0] exp_q[$];

  pmp_array #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .PAT_DEPTH(PAT_DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data             (data),
    .control          (control),
    .data_ready       (data_ready),
    .data_accepted    (data_accepted),
    .pattern_accepted (pattern_accepted),
    .match_cnt        (match_cnt)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- checking ----
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- drivers ----
  task automatic set_cmd(input int ch, input logic [1:0] op, input logic [3:0] idx,
                         input logic [3:0] ln, input logic msel, input logic [63:0] wd);
    logic [15:0] c;
    c = '0;
    c[1:0] = op;
    c[7:4] = idx;
    c[11:8] = ln;
    c[12] = msel;
    data[ch*DATA_W +: DATA_W] = wd;
    control[ch*CTRL_W +: CTRL_W] = c;
  endtask

  task automatic do_txn(input int ch, input logic [1:0] op, input logic [3:0] idx,
                        input logic [3:0] ln, input logic msel, input logic [63:0] wd);
    int n;
    set_cmd(ch, op, idx, ln, msel, wd);
    data_ready[ch] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!data_accepted[ch] && n < 8);
    check("ack_rise", {63'd0, data_accepted[ch]}, 64'd1);
    data_ready[ch] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (data_accepted[ch] && n < 8);
    check("ack_fall", {63'd0, data_accepted[ch]}, 64'd0);
  endtask

  function automatic logic [8:0] status(input int ch);
    return {pattern_accepted[ch], match_cnt[ch*8 +: 8]};
  endfunction

  task automatic add_vec(input logic [1:0] op, input logic [3:0] idx, input logic [3:0] ln,
                         input logic [63:0] wd, input logic ea, input logic [7:0] ec);
    vec_t v;
    v.op = op; v.idx = idx; v.ln = ln; v.msel = 1'b0; v.wd = wd;
    v.exp_acc = ea; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    logic [8:0] e;
    reset = 1'b1;
    data = '0;
    control = '0;
    data_ready = '0;

    repeat (3) tick();
    check("rst_ack", {60'd0, data_accepted}, 64'd0);
    check("rst_pacc", {60'd0, pattern_accepted}, 64'd0);
    check("rst_cnt", {32'd0, match_cnt}, 64'd0);
    reset = 1'b0;
    tick();

    // ---- vector table on channel 0 ----
    add_vec(C_LOAD, 4'd7, 4'd0, 64'hA, 1'b0, 8'd0);
    add_vec(C_LOAD, 4'd0, 4'd0, 64'hA, 1'b0, 8'd0);
    add_vec(C_LOAD, 4'd1, 4'd0, 64'hB, 1'b0, 8'd0);
    add_vec(C_LOAD, 4'd2, 4'd0, 64'hC, 1'b0, 8'd0);
    add_vec(C_SETLEN, 4'd0, 4'd3, 64'h0, 1'b0, 8'd0);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hA, 1'b0, 8'd0);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hA, 1'b0, 8'd0);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hB, 1'b0, 8'd0);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hC, 1'b1, 8'd1);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hA, 1'b1, 8'd1);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hB, 1'b1, 8'd1);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hD, 1'b1, 8'd1);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hA, 1'b1, 8'd1);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hB, 1'b1, 8'd1);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hC, 1'b1, 8'd2);
    add_vec(C_SETLEN, 4'd0, 4'd0, 64'h0, 1'b1, 8'd2);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hA, 1'b1, 8'd2);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hB, 1'b1, 8'd2);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hC, 1'b1, 8'd2);
    add_vec(C_SETLEN, 4'd0, 4'd3, 64'h0, 1'b1, 8'd2);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hA, 1'b1, 8'd2);
    add_vec(C_LOAD, 4'd3, 4'd0, 64'hD, 1'b0, 8'd2);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hB, 1'b0, 8'd2);
    add_vec(C_DATA, 4'd0, 4'd0, 64'hC, 1'b0, 8'd2);
    add_vec(C_CLEAR, 4'd0, 4'd0, 64'h0, 1'b0, 8'd0);

    foreach (vecs[i]) begin
      do_txn(0, vecs[i].op, vecs[i].idx, vecs[i].ln, vecs[i].msel, vecs[i].wd);
      exp_q.push_back({vecs[i].exp_acc, vecs[i].exp_cnt});
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), {55'd0, status(0)}, {55'd0, e});
    end

    // ---- saturation, LOAD keeps count, CLEAR ----
    do_txn(0, C_LOAD, 4'd0, 4'd0, 1'b0, 64'h55);
    do_txn(0, C_SETLEN, 4'd0, 4'd1, 1'b0, 64'h0);
    for (int i = 0; i < 254; i++) do_txn(0, C_DATA, 4'd0, 4'd0, 1'b0, 64'h55);
    check("sat_254", {55'd0, status(0)}, {55'd0, 9'h1FE});
    for (int i = 0; i < 46; i++) do_txn(0, C_DATA, 4'd0, 4'd0, 1'b0, 64'h55);
    check("sat_300", {55'd0, status(0)}, {55'd0, 9'h1FF});
    do_txn(0, C_LOAD, 4'd0, 4'd0, 1'b0, 64'h55);
    check("load_keeps_cnt", {55'd0, status(0)}, {55'd0, 9'h0FF});
    do_txn(0, C_CLEAR, 4'd0, 4'd0, 1'b0, 64'h0);
    check("clear", {55'd0, status(0)}, {55'd0, 9'h000});

    // ---- handshake: data_ready held 5 cycles, one execution ----
    set_cmd(0, C_DATA, 4'd0, 4'd0, 1'b0, 64'h55);
    data_ready[0] = 1'b1;
    check("hs_pre", {63'd0, data_accepted[0]}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hs_hold%0d", i), {63'd0, data_accepted[0]}, 64'd1);
    end
    check("hs_once", {55'd0, status(0)}, {55'd0, 9'h101});
    data_ready[0] = 1'b0;
    tick();
    check("hs_fall", {63'd0, data_accepted[0]}, 64'd0);
    check("hs_once_after", {55'd0, status(0)}, {55'd0, 9'h101});

    // ---- SETLEN clamp on channel 2 ----
    for (int k = 0; k < 4; k++) do_txn(2, C_LOAD, 4'(k), 4'd0, 1'b0, 64'(k + 1));
    do_txn(2, C_SETLEN, 4'd0, 4'd15, 1'b0, 64'h0);
    for (int k = 0; k < 4; k++) do_txn(2, C_DATA, 4'd0, 4'd0, 1'b0, 64'(k + 1));
    check("clamp", {55'd0, status(2)}, {55'd0, 9'h101});

    // ---- mask feature on channel 3 ----
    do_txn(3, C_LOAD, 4'd0, 4'd0, 1'b1, 64'hFF);
    do_txn(3, C_LOAD, 4'd0, 4'd0, 1'b0, 64'h12);
    do_txn(3, C_SETLEN, 4'd0, 4'd1, 1'b0, 64'h0);
    do_txn(3, C_DATA, 4'd0, 4'd0, 1'b0, 64'hAB12);
`ifdef PMP_MASK_EN
    check("mask_match", {55'd0, status(3)}, {55'd0, 9'h101});
`else
    check("nomask_exact", {55'd0, status(3)}, {55'd0, 9'h000});
    do_txn(3, C_LOAD, 4'd0, 4'd0, 1'b1, 64'hAB12);
    do_txn(3, C_DATA, 4'd0, 4'd0, 1'b0, 64'hAB12);
    check("nomask_sel_ignored", {55'd0, status(3)}, {55'd0, 9'h101});
`endif

    // ---- mid-transaction reset, all channels ----
    for (int k = 0; k < NUM_CH; k++) set_cmd(k, C_DATA, 4'd0, 4'd0, 1'b0, 64'h0);
    data_ready = '1;
    check("all_pre", {60'd0, data_accepted}, 64'd0);
    tick();
    check("all_ack", {60'd0, data_accepted}, 64'hF);
    reset = 1'b1;
    tick();
    check("mid_rst_ack", {60'd0, data_accepted}, 64'd0);
    check("mid_rst_pacc", {60'd0, pattern_accepted}, 64'd0);
    check("mid_rst_cnt", {32'd0, match_cnt}, 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ack", {60'd0, data_accepted}, 64'hF);
    data_ready = '0;
    tick();
    check("post_rst_fall", {60'd0, data_accepted}, 64'd0);

    // ---- pattern words reset to zero ----
    do_txn(1, C_SETLEN, 4'd0, 4'd1, 1'b0, 64'h0);
    do_txn(1, C_DATA, 4'd0, 4'd0, 1'b0, 64'h0);
    check("rst_pattern_zero", {55'd0, status(1)}, {55'd0, 9'h101});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
